// File: rtl/encrypt_engine.sv
// Iterative XOR/bit-permutation block cipher with run-time programmable round keys
// and permutation table; one round per clock, valid/ready on both stream sides.
module encrypt_engine #(
  parameter int DATA_W = 8,
  parameter int ROUNDS = 3,
  parameter logic [DATA_W*ROUNDS-1:0] KEY_INIT = 24'hBEADDE
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  input  logic                cfg_we,
  input  logic                cfg_sel,
  input  logic [$clog2((ROUNDS > DATA_W) ? ROUNDS : DATA_W)-1:0] cfg_addr,
  input  logic [DATA_W-1:0]   cfg_wdata,
  output logic                cfg_err
);

  localparam int IW = $clog2(DATA_W);
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              mode_q, mode_d;
  logic [RW-1:0]     rnd_q, rnd_d;
  logic              cfg_err_q, cfg_err_d;
  logic [DATA_W-1:0] key_q  [ROUNDS];
  logic [DATA_W-1:0] key_d  [ROUNDS];
  logic [IW-1:0]     perm_q [DATA_W];
  logic [IW-1:0]     perm_d [DATA_W];

  logic [DATA_W-1:0] round_x, key_sel, mixed;
  logic [RW-1:0]     dec_idx;
  logic              cfg_ok;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign cfg_err   = cfg_err_q;

  // Decrypt walks the key table backwards and undoes the permutation before the XOR.
  always_comb begin
    dec_idx = LAST - rnd_q;
    key_sel = mode_q ? key_q[dec_idx] : key_q[rnd_q];
    mixed   = '0;
    round_x = '0;
    if (mode_q) begin
      for (int i = 0; i < DATA_W; i++) mixed[perm_q[i]] = data_q[i];
      round_x = mixed ^ key_sel;
    end else begin
      mixed = data_q ^ key_sel;
      for (int i = 0; i < DATA_W; i++) round_x[i] = mixed[perm_q[i]];
    end
  end

  // Writes only land while idle with no block arriving; the perm source is range-checked
  // on the full word so out-of-range values are never silently truncated.
  assign cfg_ok = (state_q == IDLE) && !in_valid &&
                  (cfg_sel ? ((32'(cfg_addr) < DATA_W) && (cfg_wdata < DATA_W'(DATA_W)))
                           : (32'(cfg_addr) < ROUNDS));

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    mode_d     = mode_q;
    rnd_d      = rnd_q;
    out_data_d = out_data_q;
    key_d      = key_q;
    perm_d     = perm_q;
    cfg_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        rnd_d = '0;
        if (in_valid) begin
          data_d  = in_data;
          mode_d  = in_mode;
          state_d = RUN;
        end
      end
      RUN: begin
        data_d = round_x;
        if (rnd_q == LAST) begin
          out_data_d = round_x;
          state_d    = DONE;
        end else begin
          rnd_d = rnd_q + 1'b1;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (cfg_we) begin
      if (cfg_ok) begin
        if (cfg_sel) perm_d[cfg_addr[IW-1:0]] = cfg_wdata[IW-1:0];
        else         key_d[cfg_addr[RW-1:0]]  = cfg_wdata;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      mode_q     <= 1'b0;
      rnd_q      <= '0;
      out_data_q <= '0;
      cfg_err_q  <= 1'b0;
      for (int r = 0; r < ROUNDS; r++) key_q[r] <= KEY_INIT[r*DATA_W +: DATA_W];
      for (int i = 0; i < DATA_W; i++) perm_q[i] <= IW'(DATA_W - 1 - i);
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      rnd_q      <= rnd_d;
      out_data_q <= out_data_d;
      cfg_err_q  <= cfg_err_d;
      key_q      <= key_d;
      perm_q     <= perm_d;
    end
  end

endmodule

// File: tb/tb_encrypt_engine.sv
// Bench for encrypt_engine: directed scenarios plus randomized tables/blocks checked
// against a behavioural cipher model built from the round equations.
module tb_encrypt_engine;
  localparam int DW = 8;
  localparam int R  = 3;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          in_valid, in_ready, in_mode;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          cfg_we, cfg_sel, cfg_err;
  logic [2:0]    cfg_addr;
  logic [DW-1:0] cfg_wdata;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] m_key [R];
  int            m_perm [DW];

  encrypt_engine #(.DATA_W(DW), .ROUNDS(R), .KEY_INIT(24'hBEADDE)) dut (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_key[0] = 8'hDE; m_key[1] = 8'hAD; m_key[2] = 8'hBE;
    for (int i = 0; i < DW; i++) m_perm[i] = DW - 1 - i;
  endtask

  // encrypt: x <- P(x ^ k[r]); decrypt: x <- Pinv(x) ^ k[R-1-r]
  function automatic logic [DW-1:0] m_cipher(input logic [DW-1:0] d, input bit dec);
    logic [DW-1:0] x, y;
    x = d;
    for (int r = 0; r < R; r++) begin
      if (!dec) begin
        y = x ^ m_key[r];
        for (int i = 0; i < DW; i++) x[i] = y[m_perm[i]];
      end else begin
        y = '0;
        for (int i = 0; i < DW; i++) y[m_perm[i]] = x[i];
        x = y ^ m_key[R-1-r];
      end
    end
    return x;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
  endtask

  task automatic start_block(input logic [DW-1:0] d, input logic m);
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    vectors++;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL start_wait in_ready=%0b required 1 within 50 cycles", in_ready);
    end
    in_valid = 1'b1; in_data = d; in_mode = m;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finish_block(input int hold, output logic [DW-1:0] r, output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    repeat (hold) @(negedge clk);
    r = out_data;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic cfg_write(input logic sel, input logic [2:0] addr, input logic [DW-1:0] wd,
                           output logic e1, output logic e0);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = wd;
    @(negedge clk);
    cfg_we = 1'b0;
    e1 = cfg_err;
    @(negedge clk);
    e0 = cfg_err;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data got %h want 00", out_data); end
    vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL reset_cfg_err got %0b want 0", cfg_err); end
  endtask

  task automatic test_defaults();
    logic [DW-1:0] r; int lat;
    start_block(8'h00, 1'b0);
    finish_block(0, r, lat);
    vectors++; if (r !== 8'hAB) begin miscompares++; $display("FAIL default_enc got %h want ab", r); end
    vectors++; if (lat !== R) begin miscompares++; $display("FAIL default_latency got %0d want %0d", lat, R); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL default_ready_after got %0b want 1", in_ready); end
    start_block(8'hAB, 1'b1);
    finish_block(0, r, lat);
    vectors++; if (r !== 8'h00) begin miscompares++; $display("FAIL default_dec got %h want 00", r); end
  endtask

  task automatic test_identity();
    logic [DW-1:0] r, d; int lat; logic e1, e0; int errs = 0;
    for (int k = 0; k < R; k++) begin
      cfg_write(1'b0, 3'(k), 8'h00, e1, e0); errs += int'(e1) + int'(e0); m_key[k] = 8'h00;
    end
    for (int i = 0; i < DW; i++) begin
      cfg_write(1'b1, 3'(i), 8'(i), e1, e0); errs += int'(e1) + int'(e0); m_perm[i] = i;
    end
    vectors++; if (errs !== 0) begin miscompares++; $display("FAIL identity_cfg_err got %0d want 0", errs); end
    start_block(8'h5A, 1'b0);
    finish_block(0, r, lat);
    vectors++; if (r !== 8'h5A) begin miscompares++; $display("FAIL identity_enc got %h want 5a", r); end
    start_block(8'h5A, 1'b1);
    finish_block(0, r, lat);
    vectors++; if (r !== 8'h5A) begin miscompares++; $display("FAIL identity_dec got %h want 5a", r); end
    // a single nonzero key on top of identity perm must show up as a plain XOR
    cfg_write(1'b0, 3'd1, 8'h3C, e1, e0); m_key[1] = 8'h3C;
    d = 8'($urandom);
    start_block(d, 1'b0);
    finish_block(1, r, lat);
    vectors++; if (r !== (d ^ 8'h3C)) begin miscompares++; $display("FAIL identity_key1 got %h want %h", r, d ^ 8'h3C); end
    do_reset();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp; int n = 0; int bad = 0;
    exp = m_cipher(8'h3C, 1'b0);
    start_block(8'h3C, 1'b0);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
        miscompares++; bad++;
        if (bad < 4) $display("FAIL bp_hold cyc=%0d valid=%0b data=%h ready=%0b want 1 %h 0",
                              c, out_valid, out_data, in_ready, exp);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got %0b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_cfg_errors();
    logic [DW-1:0] r; int lat; logic e1, e0;
    start_block(8'h00, 1'b0);
    cfg_write(1'b0, 3'd0, 8'hFF, e1, e0);
    vectors++; if (e1 !== 1'b1 || e0 !== 1'b0) begin miscompares++; $display("FAIL err_run pulse got %0b%0b want 10", e1, e0); end
    finish_block(0, r, lat);
    vectors++; if (r !== 8'hAB) begin miscompares++; $display("FAIL err_run_result got %h want ab", r); end
    cfg_write(1'b0, 3'd3, 8'h00, e1, e0);
    vectors++; if (e1 !== 1'b1 || e0 !== 1'b0) begin miscompares++; $display("FAIL err_keyidx pulse got %0b%0b want 10", e1, e0); end
    cfg_write(1'b1, 3'd0, 8'h08, e1, e0);
    vectors++; if (e1 !== 1'b1 || e0 !== 1'b0) begin miscompares++; $display("FAIL err_permval pulse got %0b%0b want 10", e1, e0); end
    in_valid = 1'b1; in_data = 8'h00; in_mode = 1'b0;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 3'd0; cfg_wdata = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
    vectors++; if (cfg_err !== 1'b1) begin miscompares++; $display("FAIL err_inval pulse got %0b want 1", cfg_err); end
    @(negedge clk);
    vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL err_inval width got %0b want 0", cfg_err); end
    finish_block(0, r, lat);
    vectors++; if (r !== 8'hAB) begin miscompares++; $display("FAIL err_inval_result got %h want ab", r); end
    start_block(8'h00, 1'b0);
    finish_block(0, r, lat);
    vectors++; if (r !== 8'hAB) begin miscompares++; $display("FAIL err_tables_enc0 got %h want ab", r); end
    start_block(8'h5A, 1'b0);
    finish_block(0, r, lat);
    vectors++; if (r !== m_cipher(8'h5A, 1'b0)) begin miscompares++; $display("FAIL err_tables_enc5a got %h want %h", r, m_cipher(8'h5A, 1'b0)); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] r; int lat; logic e1, e0; int bad = 0;
    cfg_write(1'b0, 3'd0, 8'hFF, e1, e0);
    vectors++; if (e1 !== 1'b0) begin miscompares++; $display("FAIL rstmid_cfg got %0b want 0", e1); end
    start_block(8'h00, 1'b0);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid_in_reset got %0b want 0", out_valid); end
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready got %0b want 1", in_ready); end
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL rstmid_no_output got %0d valid cycles want 0", bad); end
    start_block(8'h00, 1'b0);
    finish_block(0, r, lat);
    vectors++; if (r !== 8'hAB) begin miscompares++; $display("FAIL rstmid_enc got %h want ab", r); end
  endtask

  task automatic test_random();
    logic [DW-1:0] d, c, p, kv; int lat, j, tmp, errs = 0, bad = 0; logic e1, e0;
    for (int k = 0; k < R; k++) begin
      kv = 8'($urandom);
      cfg_write(1'b0, 3'(k), kv, e1, e0); errs += int'(e1); m_key[k] = kv;
    end
    for (int i = 0; i < DW; i++) m_perm[i] = i;
    for (int i = DW - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i)); tmp = m_perm[i]; m_perm[i] = m_perm[j]; m_perm[j] = tmp;
    end
    for (int i = 0; i < DW; i++) begin
      cfg_write(1'b1, 3'(i), 8'(m_perm[i]), e1, e0); errs += int'(e1);
    end
    vectors++; if (errs !== 0) begin miscompares++; $display("FAIL rand_cfg got %0d errors want 0", errs); end
    for (int n = 0; n < 1000; n++) begin
      d = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_block(d, 1'b0);
      finish_block(int'($urandom_range(0, 3)), c, lat);
      vectors++;
      if (c !== m_cipher(d, 1'b0) || lat !== R) begin
        miscompares++; bad++;
        if (bad < 6) $display("FAIL rand_enc n=%0d d=%h got %h lat %0d want %h lat %0d", n, d, c, lat, m_cipher(d, 1'b0), R);
      end
      start_block(c, 1'b1);
      finish_block(int'($urandom_range(0, 3)), p, lat);
      vectors++;
      if (p !== d || p !== m_cipher(c, 1'b1)) begin
        miscompares++; bad++;
        if (bad < 6) $display("FAIL rand_roundtrip n=%0d c=%h got %h want %h", n, c, p, d);
      end
    end
  endtask

  initial begin
    n_rst = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    model_reset();
    test_reset();
    test_defaults();
    test_identity();
    test_backpressure();
    test_cfg_errors();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/encrypt_engine.md
# encrypt_engine

Parametrised, iterative block cipher core: each block runs ROUNDS rounds of XOR-with-round-key plus bit permutation, in encrypt or decrypt mode selected per block. Round keys and the permutation table are run-time programmable through a small config port. Reset loads the legacy fixed constants, so an unconfigured core matches the existing 8-bit, 3-key, bit-reversal scheme. The core sits between the host-side input stream and the output stream, with valid/ready handshakes on both sides.

## Interface
- DATA_W, 8, block width in bits (≥2)
- ROUNDS, 3, number of rounds and round keys (≥1)
- KEY_INIT, 24'hBEADDE, DATA_W*ROUNDS bits of reset keys; key r = bits [r*DATA_W +: DATA_W] (default k0=DE, k1=AD, k2=BE)
- clk  in  1  clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input block present
- in_ready  out  1  core can accept a block
- in_data  in  DATA_W  plaintext or ciphertext
- in_mode  in  1  0 = encrypt, 1 = decrypt; sampled with in_data
- out_valid  out  1  result present
- out_ready  in  1  sink accepts result
- out_data  out  DATA_W  result
- cfg_we  in  1  config write strobe
- cfg_sel  in  1  0 = key table, 1 = permutation table
- cfg_addr  in  clog2(max(ROUNDS,DATA_W))  key index or permutation bit index
- cfg_wdata  in  DATA_W  key value, or source bit index in low clog2(DATA_W) bits
- cfg_err  out  1  one-cycle pulse: config write rejected

## Operation
- Permutation table perm[i], i in 0..DATA_W-1; P(x)[i] = x[perm[i]]; inverse Pinv(x)[perm[i]] = x[i].
- Encrypt round r (r = 0..ROUNDS-1): x ← P(x ^ key[r]).
- Decrypt round r: x ← Pinv(x) ^ key[ROUNDS-1-r]. Decrypt(encrypt(d)) = d for any bijective perm table.
- FSM: IDLE → RUN on in_valid & in_ready; RUN → DONE after ROUNDS round cycles; DONE → IDLE on out_valid & out_ready.
- IDLE: in_ready=1; data and mode latched on accept; round counter cleared.
- RUN: one round per cycle; round counter increments; last round writes the result register and moves to DONE.
- DONE: out_valid=1, out_data stable until handshake.
- Config writes honoured only in IDLE and with no simultaneous input accept. Rejected (table unchanged, cfg_err pulses the next cycle) when: state ≠ IDLE, in_valid & cfg_we in the same IDLE cycle, key index ≥ ROUNDS, perm index ≥ DATA_W, or perm source value ≥ DATA_W.
- Permutation bijectivity is not checked; software owns it. Non-bijective tables give undefined decrypt results but no lockup.
- Reset values: state IDLE, in_ready=1 (after reset release), out_valid=0, out_data=0, cfg_err=0, key[r]=KEY_INIT slice r, perm[i]=DATA_W-1-i (bit reversal).
- Reset mid-operation aborts the block; no partial output is produced and tables revert to reset values.

## Timing
- Accept edge t; round edges t+1..t+ROUNDS; out_valid high in cycle after edge t+ROUNDS (latency ROUNDS cycles accept-to-valid).
- Output handshake edge u → in_ready high in cycle after u; no same-cycle bypass from DONE to RUN.
- Max throughput: one block per ROUNDS+2 cycles.
- Config write takes effect at the write edge; a block accepted in a later cycle uses the new value.
- cfg_err asserted exactly one cycle, registered, after the offending cfg_we edge.
- in_ready is a function of registered state only; out_valid/out_data registered.

## Test plan
- Defaults, encrypt 0x00 -> out_data=0xAB after 3 cycles; decrypt 0xAB -> 0x00.
- Write keys 0,0,0 and perm[i]=i (identity), encrypt 0x5A -> 0x5A; decrypt 0x5A -> 0x5A.
- out_ready held low 10 cycles in DONE -> out_valid and out_data stay constant, in_ready stays 0; release -> in_ready=1 next cycle.
- cfg_we during RUN, key index 3, perm value 8, and cfg_we with in_valid in IDLE -> each gives one-cycle cfg_err, tables unchanged (re-encrypt 0x00 still 0xAB).
- n_rst asserted in RUN after reprogramming key0=0xFF -> out_valid=0, in_ready=1 after release, encrypt 0x00 -> 0xAB.
- Random key/bijective perm tables, 1000 random blocks, random backpressure -> decrypt(encrypt(d)) = d, results match reference model in order.
